// File: rtl/store_bram_writer.sv
// Packs LANES consecutive stream words into one BRAM line and writes each full line
// to an auto-incrementing address; store_done pulses once the programmed line count is stored.
module store_bram_writer #(
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 11,
    localparam int LANES  = LINE_W / DATA_W,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_store,
    input  logic              reset_addr_counter,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_lines,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [LINE_W-1:0] bram_din,
    output logic              busy,
    output logic              store_done
);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     lines_left;
    logic [LANE_W-1:0]   lane;
    logic [LINE_W-1:0]   line, line_nxt;
    logic                acc, last_acc;

    // s_ready is a registered state decode, so acceptance never depends combinationally on s_valid
    assign acc      = s_valid && s_ready;
    assign last_acc = acc && (lane == LANE_W'(LANES - 1));

    always_comb begin
        line_nxt = line;
        if (acc)
            line_nxt[int'(lane)*DATA_W +: DATA_W] = s_data;
    end

    always_comb begin
        state_nxt = state;
        if (reset_addr_counter)
            state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    if (start_store) state_nxt = (num_lines != '0) ? PACK : DONE;
                PACK:    if (last_acc) state_nxt = WRITE;
                WRITE:   state_nxt = (lines_left == (ADDR_W+1)'(1)) ? DONE : PACK;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            lines_left <= '0;
            lane       <= '0;
            line       <= '0;
            s_ready    <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            busy       <= 1'b0;
            store_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            s_ready    <= (state_nxt == PACK);
            bram_en    <= (state_nxt == WRITE);
            bram_we    <= (state_nxt == WRITE);
            busy       <= (state_nxt != IDLE);
            store_done <= (state_nxt == DONE);

            if (reset_addr_counter) begin
                wr_ptr <= '0;
                lane   <= '0;
                line   <= '0;
            end else begin
                case (state)
                    IDLE: if (start_store) begin
                        wr_ptr     <= base_addr;
                        lines_left <= num_lines;
                        lane       <= '0;
                    end
                    PACK: if (acc) begin
                        line <= line_nxt;
                        lane <= lane + 1'b1;
                        // the output registers are loaded here so they are valid for the whole WRITE cycle
                        if (last_acc) begin
                            bram_addr <= wr_ptr;
                            bram_din  <= line_nxt;
                        end
                    end
                    WRITE: begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        lines_left <= lines_left - 1'b1;
                        lane       <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
